// File: rtl/unit_run_sequencer.sv
// Run controller: launches NUM_UNITS sub-units in index order over a start/done handshake,
// accumulates their error counts (saturating) and aborts on a per-unit watchdog timeout.
module unit_run_sequencer #(
  parameter int NUM_UNITS = 10,
  parameter int TIMEOUT   = 1000,
  parameter int ERR_W     = 16,
  localparam int CUR_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int WD_W     = $clog2(TIMEOUT + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  output logic [NUM_UNITS-1:0]       unit_start,
  input  logic [NUM_UNITS-1:0]       unit_done,
  input  logic [NUM_UNITS*ERR_W-1:0] unit_err,
  output logic                       busy,
  output logic                       run_done,
  output logic                       pass,
  output logic                       timed_out,
  output logic [CUR_W-1:0]           cur_unit,
  output logic [ERR_W-1:0]           total_errors
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_REPORT} state_t;

  state_t           r_state, w_state_nxt;
  logic [CUR_W-1:0] r_cur;
  logic [WD_W-1:0]  r_wdog;
  logic [ERR_W-1:0] r_total;
  logic             r_pass;
  logic             r_timed_out;

  logic             w_done_cur;
  logic [ERR_W-1:0] w_err_cur;
  logic             w_last;
  logic             w_expire;
  logic [ERR_W-1:0] w_add;
  logic [ERR_W:0]   w_sum;
  logic [ERR_W-1:0] w_sat;

  assign w_done_cur = unit_done[r_cur];
  assign w_err_cur  = unit_err[r_cur*ERR_W +: ERR_W];
  assign w_last     = (r_cur == CUR_W'(NUM_UNITS - 1));
  // Watchdog holds the count of completed WAIT cycles; this is the last cycle a done is accepted.
  assign w_expire   = (r_wdog == WD_W'(TIMEOUT - 1));

  // Done wins over expiry; a timeout charges one error against the run.
  assign w_add = w_done_cur ? w_err_cur : ERR_W'(1);
  assign w_sum = {1'b0, r_total} + {1'b0, w_add};
  assign w_sat = w_sum[ERR_W] ? {ERR_W{1'b1}} : w_sum[ERR_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (run) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done_cur)    w_state_nxt = w_last ? S_REPORT : S_LAUNCH;
        else if (w_expire) w_state_nxt = S_REPORT;
      end
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_wdog      <= '0;
      r_total     <= '0;
      r_pass      <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_cur       <= '0;
            r_total     <= '0;
            r_pass      <= 1'b0;
            r_timed_out <= 1'b0;
          end
        end
        S_LAUNCH: r_wdog <= '0;
        S_WAIT: begin
          r_wdog <= r_wdog + WD_W'(1);
          if (w_done_cur) begin
            r_total <= w_sat;
            if (w_last) r_pass <= (w_sat == '0);
            else        r_cur  <= r_cur + CUR_W'(1);
          end else if (w_expire) begin
            r_total     <= w_sat;
            r_timed_out <= 1'b1;
            r_pass      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    unit_start = '0;
    if (r_state == S_LAUNCH) unit_start[r_cur] = 1'b1;
  end

  assign busy         = (r_state == S_LAUNCH) || (r_state == S_WAIT);
  assign run_done     = (r_state == S_REPORT);
  assign pass         = r_pass;
  assign timed_out    = r_timed_out;
  assign cur_unit     = r_cur;
  assign total_errors = r_total;

endmodule

// File: tb/tb_unit_run_sequencer.sv
// Directed bench for unit_run_sequencer (4 units, TIMEOUT=20): ordering, timing, timeout,
// expiry-cycle race, spurious inputs, saturation and mid-run reset.
module tb_unit_run_sequencer;
  localparam int NU = 4;
  localparam int TO = 20;
  localparam int EW = 16;

  logic              clk;
  logic              rst_n;
  logic              run;
  logic [NU-1:0]     unit_start;
  logic [NU-1:0]     unit_done;
  logic [NU*EW-1:0]  unit_err;
  logic              busy, run_done, pass, timed_out;
  logic [1:0]        cur_unit;
  logic [EW-1:0]     total_errors;

  unit_run_sequencer #(.NUM_UNITS(NU), .TIMEOUT(TO), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .unit_start(unit_start), .unit_done(unit_done),
    .unit_err(unit_err), .busy(busy), .run_done(run_done), .pass(pass), .timed_out(timed_out),
    .cur_unit(cur_unit), .total_errors(total_errors)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int start_cnt [NU];
  int start_cyc [NU];
  int rd_cnt, rd_cyc, multi;
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NU; i++)
      if (unit_start[i]) begin
        start_cnt[i] = start_cnt[i] + 1;
        start_cyc[i] = cyc;
      end
    if ($countones(unit_start) > 1) multi = multi + 1;
    if (run_done) begin
      rd_cnt = rd_cnt + 1;
      rd_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    for (int i = 0; i < NU; i++) begin
      start_cnt[i] = 0;
      start_cyc[i] = 0;
    end
    rd_cnt = 0;
    rd_cyc = 0;
    multi  = 0;
  endtask

  task automatic do_run(output int c0);
    run = 1'b1;
    c0  = cyc;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_start(input int idx, output int s);
    int k = 0;
    while (start_cnt[idx] == 0 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (start_cnt[idx] == 0) chk($sformatf("start%0d_timeout", idx), 0, 1);
    s = start_cyc[idx];
  endtask

  // Answer unit idx dly cycles after its start pulse, holding done for hold cycles.
  task automatic serve(input int idx, input int dly, input logic [EW-1:0] e, input int hold);
    int s;
    wait_start(idx, s);
    while (cyc < s + dly) tick();
    unit_done[idx] = 1'b1;
    unit_err[idx*EW +: EW] = e;
    repeat (hold) tick();
    unit_done[idx] = 1'b0;
  endtask

  task automatic wait_rd();
    int k = 0;
    while (rd_cnt == 0 && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (rd_cnt == 0) chk("run_done_timeout", 0, 1);
  endtask

  int c0, s0, s2;

  initial begin
    rst_n = 1'b0; run = 1'b0; unit_done = '0; unit_err = '0;
    clr_mon();
    #3;
    chk("rst_start", 32'(unit_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {29'd0, run_done, pass, timed_out}, 0);
    chk("rst_total", 32'(total_errors), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: all units clean
    clr_mon();
    do_run(c0);
    chk("t1_busy", 32'(busy), 1);
    for (int i = 0; i < NU; i++) serve(i, 5, 16'h0, 1);
    wait_rd();
    chk("t1_rd_cnt", 32'(rd_cnt), 1);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_total", 32'(total_errors), 0);
    chk("t1_timeout", 32'(timed_out), 0);
    chk("t1_starts", {start_cnt[3][7:0], start_cnt[2][7:0], start_cnt[1][7:0], start_cnt[0][7:0]}, 32'h01010101);
    chk("t1_multi", 32'(multi), 0);
    chk("t1_gap01", 32'(start_cyc[1] - start_cyc[0]), 6);
    chk("t1_gap23", 32'(start_cyc[3] - start_cyc[2]), 6);
    tick(); tick();

    // 2: error accumulation and run timing
    clr_mon();
    do_run(c0);
    serve(0, 5, 16'd3, 1);
    serve(1, 5, 16'd0, 1);
    serve(2, 5, 16'd7, 1);
    serve(3, 5, 16'd1, 1);
    wait_rd();
    chk("t2_start0", 32'(start_cyc[0] - c0), 1);
    chk("t2_rd_time", 32'(rd_cyc - c0), 25);
    chk("t2_total", 32'(total_errors), 11);
    chk("t2_pass", 32'(pass), 0);
    tick(); tick();

    // 3: unit 2 never answers
    clr_mon();
    do_run(c0);
    serve(0, 3, 16'd2, 1);
    serve(1, 3, 16'd4, 1);
    wait_start(2, s2);
    wait_rd();
    chk("t3_rd_time", 32'(rd_cyc - s2), 21);
    chk("t3_timeout", 32'(timed_out), 1);
    chk("t3_cur", 32'(cur_unit), 2);
    chk("t3_total", 32'(total_errors), 7);
    chk("t3_pass", 32'(pass), 0);
    chk("t3_no_start3", 32'(start_cnt[3]), 0);
    repeat (3) tick();
    @(negedge clk);
    chk("t3_hold_to", 32'(timed_out), 1);
    chk("t3_hold_total", 32'(total_errors), 7);
    chk("t3_hold_busy", 32'(busy), 0);
    tick();

    // 4: done on the expiry cycle, spurious done, run while busy, level-held done
    clr_mon();
    do_run(c0);
    wait_start(0, s0);
    while (cyc < s0 + 3) tick();
    unit_done[3] = 1'b1;
    unit_err[3*EW +: EW] = 16'h0055;
    run = 1'b1;
    tick();
    unit_done[3] = 1'b0;
    run = 1'b0;
    while (cyc < s0 + TO) tick();
    unit_done[0] = 1'b1;
    unit_err[0 +: EW] = 16'h0;
    tick();
    unit_done[0] = 1'b0;
    serve(1, 2, 16'd5, 3);
    serve(2, 2, 16'd0, 1);
    serve(3, 2, 16'd0, 1);
    wait_rd();
    chk("t4_gap01", 32'(start_cyc[1] - start_cyc[0]), TO + 1);
    chk("t4_timeout", 32'(timed_out), 0);
    chk("t4_total", 32'(total_errors), 5);
    chk("t4_restart", 32'(start_cnt[0]), 1);
    chk("t4_start3", 32'(start_cnt[3]), 1);
    tick(); tick();

    // 5: saturation
    clr_mon();
    do_run(c0);
    serve(0, 1, 16'hFFF0, 1);
    serve(1, 1, 16'h0020, 1);
    serve(2, 1, 16'h0001, 1);
    serve(3, 1, 16'h0000, 1);
    wait_rd();
    chk("t5_total", 32'(total_errors), 32'hFFFF);
    chk("t5_pass", 32'(pass), 0);
    tick(); tick();

    // 6: reset mid-run
    clr_mon();
    do_run(c0);
    serve(0, 2, 16'd9, 1);
    wait_start(1, s0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t6_start", 32'(unit_start), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_cur", 32'(cur_unit), 0);
    chk("t6_total", 32'(total_errors), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_no_rd", 32'(rd_cnt), 0);
    clr_mon();
    do_run(c0);
    for (int i = 0; i < NU; i++) serve(i, 1, 16'h0, 1);
    wait_rd();
    chk("t6_start0", 32'(start_cyc[0] - c0), 1);
    chk("t6_pass", 32'(pass), 1);
    chk("t6_starts", {start_cnt[3][7:0], start_cnt[2][7:0], start_cnt[1][7:0], start_cnt[0][7:0]}, 32'h01010101);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
